// File: rtl/frame_update_scheduler_pkg.sv
// frame_sched_pkg: shared types and defaults for the frame update scheduler
package frame_sched_pkg;
  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} sched_state_t;
  localparam int STG_INPUT          = 0;
  localparam int STG_BIRD           = 1;
  localparam int STG_PIPES          = 2;
  localparam int STG_COLLIDE        = 3;
  localparam int NUM_STAGES_DEF     = 4;
  localparam int TIMEOUT_CYCLES_DEF = 4096;
  localparam int CNT_W_DEF          = 16;
endpackage

// File: rtl/frame_update_scheduler_if.sv
// frame_update_scheduler_if: start/done handshake between scheduler and update stages
interface frame_update_scheduler_if
  import frame_sched_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF
);
  logic [NUM_STAGES-1:0] stage_start;
  logic [NUM_STAGES-1:0] stage_done;
  modport master (output stage_start, input stage_done);
  modport slave  (input stage_start, output stage_done);
endinterface

// File: rtl/frame_update_scheduler_timer.sv
// sched_stage_timer: clearable per-stage wait counter with terminal-count flag
module sched_stage_timer
  import frame_sched_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  // clear wins over count so each stage starts its wait from zero
  always_comb cnt_d = clr_i ? '0 : en_i ? cnt_q + CW'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign tc_o = cnt_q == CW'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/frame_update_scheduler.sv
// frame_update_scheduler: runs ordered game-logic stages inside each vertical blank
module frame_update_scheduler
  import frame_sched_pkg::*;
#(
  parameter int NUM_STAGES     = NUM_STAGES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = CNT_W_DEF,
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblnk_in,
  input  logic                  enable,
  input  logic                  clr_status,
  frame_update_scheduler_if.master bus,
  output logic                  frame_tick,
  output logic                  frame_done,
  output logic                  busy,
  output logic [IW-1:0]         stage_idx,
  output logic [NUM_STAGES-1:0] stage_timeout,
  output logic [CNT_W-1:0]      frame_cnt,
  output logic [CNT_W-1:0]      overrun_cnt
);
  sched_state_t          state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  vblnk_prev_q;
  logic [NUM_STAGES-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d, overrun_q, overrun_d;
  logic                  vblnk_rise, vblnk_fall, tc, done_sel, last, adv, abort;

  assign vblnk_rise = vblnk_in & ~vblnk_prev_q;
  assign vblnk_fall = ~vblnk_in & vblnk_prev_q;
  assign done_sel   = bus.stage_done[idx_q];
  assign last       = idx_q == IW'(NUM_STAGES - 1);
  assign adv        = (state_q == WAIT) && (done_sel || tc);
  // completing the last stage beats a coincident end of blanking
  assign abort      = vblnk_fall && ((state_q == START) || ((state_q == WAIT) && !(adv && last)));

  sched_stage_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == START),
    .en_i (state_q == WAIT),
    .tc_o (tc)
  );

  // state and status registers; vblnk_prev resets high so a blank already in progress is not a new frame
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      vblnk_prev_q <= 1'b1;
      timeout_q    <= '0;
      frame_cnt_q  <= '0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      vblnk_prev_q <= vblnk_in;
      timeout_q    <= timeout_d;
      frame_cnt_q  <= frame_cnt_d;
      overrun_q    <= overrun_d;
    end
  end

  // next state: timeout advances exactly like a done; clr_status overrides same-cycle updates
  always_comb begin
    case (state_q)
      IDLE:    state_d = (vblnk_rise && enable) ? START : IDLE;
      START:   state_d = abort ? IDLE : WAIT;
      WAIT:    state_d = abort ? IDLE : !adv ? WAIT : last ? DONE : START;
      default: state_d = IDLE;
    endcase
    idx_d       = (state_d == IDLE) ? '0 : ((state_q == WAIT) && (state_d == START)) ? idx_q + IW'(1) : idx_q;
    frame_cnt_d = frame_cnt_q + CNT_W'(state_q == DONE);
    overrun_d   = clr_status ? '0 : overrun_q + CNT_W'(abort && !(&overrun_q));
    timeout_d   = clr_status ? '0 :
                  timeout_q | (((state_q == WAIT) && tc && !done_sel) ? NUM_STAGES'(1) << idx_q : '0);
  end

  // outputs decoded from the registered state
  always_comb begin
    bus.stage_start = (state_q == START) ? NUM_STAGES'(1) << idx_q : '0;
    frame_tick      = (state_q == START) && (idx_q == IW'(STG_INPUT));
    frame_done      = state_q == DONE;
    busy            = state_q != IDLE;
  end

  assign stage_idx     = idx_q;
  assign stage_timeout = timeout_q;
  assign frame_cnt     = frame_cnt_q;
  assign overrun_cnt   = overrun_q;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// tb_frame_update_scheduler: directed checks of frame sequencing, timeout, overrun, gating and reset
module tb_frame_update_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk_in = 1'b1;
  logic        enable = 1'b1;
  logic        clr_status = 1'b0;
  logic        frame_tick, frame_done, busy;
  logic [1:0]  stage_idx;
  logic [3:0]  stage_timeout;
  logic [15:0] frame_cnt, overrun_cnt;
  int nvec = 0, nerr = 0, cyc = 0;
  int dly[4];
  int st[4];
  int ss[4];
  int ft, fd;

  frame_update_scheduler_if #(.NUM_STAGES(4)) bus ();

  frame_update_scheduler #(.NUM_STAGES(4), .TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .vblnk_in(vblnk_in), .enable(enable), .clr_status(clr_status),
    .bus(bus), .frame_tick(frame_tick), .frame_done(frame_done), .busy(busy),
    .stage_idx(stage_idx), .stage_timeout(stage_timeout), .frame_cnt(frame_cnt),
    .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic clear_log();
    for (int i = 0; i < 4; i++) begin st[i] = -1; ss[i] = -1; end
    ft = -1; fd = -1;
  endtask

  task automatic step();
    logic [3:0] dn;
    @(posedge clk); #1;
    cyc++;
    dn = '0;
    for (int i = 0; i < 4; i++) begin
      if (bus.stage_start[i]) begin st[i] = cyc; ss[i] = cyc; end
      if (dly[i] != 0 && st[i] >= 0 && cyc == st[i] + dly[i]) dn[i] = 1'b1;
    end
    if (frame_tick) ft = cyc;
    if (frame_done) fd = cyc;
    bus.stage_done = dn;
  endtask

  task automatic new_blank();
    vblnk_in = 1'b0;
    repeat (2) step();
    clear_log();
    vblnk_in = 1'b1;
  endtask

  task automatic wait_start(input int s);
    int n = 0;
    while (ss[s] < 0 && n < 100) begin step(); n++; end
  endtask

  task automatic test_reset();
    repeat (3) step();
    nvec++;
    if ({bus.stage_start, frame_tick, frame_done, busy, stage_idx, stage_timeout, frame_cnt, overrun_cnt} !== 46'd0) begin
      nerr++; $display("FAIL reset_outputs: got busy=%b cnt=%0d, required all zero", busy, frame_cnt);
    end
    rst = 1'b0;
    clear_log();
    repeat (5) step();
    nvec++;
    if (ft !== -1 || busy !== 1'b0) begin
      nerr++; $display("FAIL reset_vblnk_high: got tick_cycle=%0d busy=%b, required no tick, busy 0", ft, busy);
    end
  endtask

  task automatic test_basic();
    int exp_ss[4] = '{11, 17, 23, 29};
    vblnk_in = 1'b0;
    repeat (3) step();
    clear_log();
    cyc = 0;
    while (cyc < 10) step();
    vblnk_in = 1'b1;
    repeat (30) step();
    nvec++;
    if (ft !== 11) begin nerr++; $display("FAIL basic_tick: got cycle %0d, required 11", ft); end
    for (int i = 0; i < 4; i++) begin
      nvec++;
      if (ss[i] !== exp_ss[i]) begin nerr++; $display("FAIL basic_start%0d: got cycle %0d, required %0d", i, ss[i], exp_ss[i]); end
    end
    nvec++;
    if (fd !== 35) begin nerr++; $display("FAIL basic_done: got cycle %0d, required 35", fd); end
    nvec++;
    if (frame_cnt !== 16'd1 || stage_timeout !== 4'b0000) begin
      nerr++; $display("FAIL basic_counts: got frame_cnt=%0d timeout=%b, required 1 and 0000", frame_cnt, stage_timeout);
    end
  endtask

  task automatic test_timeout();
    dly = '{5, 5, 0, 5};
    new_blank();
    repeat (60) step();
    nvec++;
    if (ss[2] < 0 || ss[3] - ss[2] !== 9) begin
      nerr++; $display("FAIL timeout_gap: got start2=%0d start3=%0d, required gap 9", ss[2], ss[3]);
    end
    nvec++;
    if (stage_timeout !== 4'b0100) begin nerr++; $display("FAIL timeout_flag: got %b, required 0100", stage_timeout); end
    nvec++;
    if (fd < 0 || frame_cnt !== 16'd2) begin
      nerr++; $display("FAIL timeout_done: got done_cycle=%0d frame_cnt=%0d, required done and 2", fd, frame_cnt);
    end
    dly = '{5, 5, 5, 5};
  endtask

  task automatic test_overrun();
    new_blank();
    wait_start(1);
    repeat (2) step();
    vblnk_in = 1'b0;
    step();
    nvec++;
    if (busy !== 1'b0) begin nerr++; $display("FAIL overrun_busy: got %b, required 0", busy); end
    repeat (20) step();
    nvec++;
    if (ss[2] !== -1) begin nerr++; $display("FAIL overrun_nostart: got start2 at %0d, required none", ss[2]); end
    nvec++;
    if (overrun_cnt !== 16'd1 || frame_cnt !== 16'd2) begin
      nerr++; $display("FAIL overrun_counts: got overrun=%0d frame_cnt=%0d, required 1 and 2", overrun_cnt, frame_cnt);
    end
  endtask

  task automatic test_overrun_coincide();
    new_blank();
    wait_start(3);
    while (ss[3] >= 0 && cyc < ss[3] + 5) step();
    vblnk_in = 1'b0;
    step();
    nvec++;
    if (frame_done !== 1'b1) begin nerr++; $display("FAIL coincide_done: got %b, required 1", frame_done); end
    repeat (3) step();
    nvec++;
    if (overrun_cnt !== 16'd1 || frame_cnt !== 16'd3) begin
      nerr++; $display("FAIL coincide_counts: got overrun=%0d frame_cnt=%0d, required 1 and 3", overrun_cnt, frame_cnt);
    end
  endtask

  task automatic test_enable();
    enable = 1'b0;
    new_blank();
    repeat (10) step();
    nvec++;
    if (ft !== -1 || busy !== 1'b0) begin
      nerr++; $display("FAIL enable_block: got tick_cycle=%0d busy=%b, required no tick", ft, busy);
    end
    enable = 1'b1;
    new_blank();
    wait_start(0);
    enable = 1'b0;
    repeat (40) step();
    nvec++;
    if (fd < 0 || frame_cnt !== 16'd4) begin
      nerr++; $display("FAIL enable_drop: got done_cycle=%0d frame_cnt=%0d, required done and 4", fd, frame_cnt);
    end
    enable = 1'b1;
  endtask

  task automatic test_clear();
    nvec++;
    if (stage_timeout !== 4'b0100 || overrun_cnt !== 16'd1) begin
      nerr++; $display("FAIL clear_pre: got timeout=%b overrun=%0d, required 0100 and 1", stage_timeout, overrun_cnt);
    end
    clr_status = 1'b1;
    step();
    clr_status = 1'b0;
    nvec++;
    if (stage_timeout !== 4'b0000 || overrun_cnt !== 16'd0) begin
      nerr++; $display("FAIL clear_post: got timeout=%b overrun=%0d, required 0000 and 0", stage_timeout, overrun_cnt);
    end
  endtask

  task automatic test_reset_mid();
    new_blank();
    wait_start(0);
    repeat (2) step();
    nvec++;
    if (busy !== 1'b1) begin nerr++; $display("FAIL midrst_busy: got %b, required 1", busy); end
    rst = 1'b1;
    step();
    nvec++;
    if ({bus.stage_start, frame_tick, frame_done, busy, stage_idx, stage_timeout, frame_cnt, overrun_cnt} !== 46'd0) begin
      nerr++; $display("FAIL midrst_outputs: got busy=%b start=%b cnt=%0d, required all zero", busy, bus.stage_start, frame_cnt);
    end
    rst = 1'b0;
    step();
  endtask

  initial begin
    bus.stage_done = '0;
    dly = '{5, 5, 5, 5};
    clear_log();
    test_reset();
    test_basic();
    test_timeout();
    test_overrun();
    test_overrun_coincide();
    test_enable();
    test_clear();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
